reservoir_plant_model: RTL

Behavioural-synthesisable plant model of the water reservoir that closes the loop around the level-controller FSM. It consumes the controller's valve commands (fr3, fr2, fr1, dfr), integrates inflow minus a programmable drain into a saturating level register on a prescaled tick, and drives the three level sensors s[3:1] back to the controller. Used in system-level benches and FPGA demos in place of real sensors.

---
 rtl/reservoir_plant_model_if.sv | 29 ++
 rtl/reservoir_plant_model.sv | 86 ++++++++
 2 files changed

// File: rtl/reservoir_plant_model_if.sv
// Valve/drain/preset inputs and sensor/level/flag outputs of the reservoir plant model.
// The master side belongs to the level controller or bench; the slave side belongs to the plant.
interface reservoir_plant_model_if #(
  parameter int LEVEL_W = 8
);
  logic               fr1;
  logic               fr2;
  logic               fr3;
  logic               dfr;
  logic [3:0]         drain_rate;
  logic               load_en;
  logic [LEVEL_W-1:0] load_val;
  logic               flag_clr;
  logic [3:1]         s;
  logic [LEVEL_W-1:0] level;
  logic               tick;
  logic               ovf_flag;
  logic               dry_flag;

  modport master (
    output fr1, fr2, fr3, dfr, drain_rate, load_en, load_val, flag_clr,
    input  s, level, tick, ovf_flag, dry_flag
  );

  modport slave (
    input  fr1, fr2, fr3, dfr, drain_rate, load_en, load_val, flag_clr,
    output s, level, tick, ovf_flag, dry_flag
  );
endinterface

// File: rtl/reservoir_plant_model.sv
// Reservoir plant: integrates valve inflow minus drain into a saturating level on each prescaled tick.
// Level and s update one clock after a tick or load edge; there is no backpressure, inputs are sampled on those edges only.
module reservoir_plant_model #(
  parameter int LEVEL_W   = 8,
  parameter int LEVEL_MAX = 200,
  parameter int T1        = 50,
  parameter int T2        = 100,
  parameter int T3        = 150,
  parameter int RATE_FR1  = 4,
  parameter int RATE_FR2  = 4,
  parameter int RATE_FR3  = 4,
  parameter int RATE_DFR  = 2,
  parameter int TICK_DIV  = 4
) (
  input logic clk,
  input logic areset_n,
  reservoir_plant_model_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = LEVEL_W + 3;
  localparam int IW = LEVEL_W + 2;
  localparam logic signed [RW-1:0] MAX_S = RW'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0]   MAX_U = LEVEL_W'(LEVEL_MAX);

  logic [PW-1:0]          presc;
  logic                   tick;
  logic [LEVEL_W-1:0]     lvl, lvl_nxt;
  logic [3:1]             s_q, s_nxt;
  logic                   ovf_q, dry_q, ovf_set, dry_set;
  logic [IW-1:0]          inflow;
  logic signed [RW-1:0]   raw;

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_comb begin
    inflow = (bus.fr1 ? IW'(RATE_FR1) : '0)
           + (bus.fr2 ? IW'(RATE_FR2) : '0)
           + (bus.fr3 ? IW'(RATE_FR3) : '0)
           + (bus.dfr ? IW'(RATE_DFR) : '0);
    raw = $signed({3'b000, lvl}) + $signed({1'b0, inflow})
        - $signed({{(RW-4){1'b0}}, bus.drain_rate});
  end

  // Load beats the tick; the integration result of that edge is dropped.
  always_comb begin
    lvl_nxt = lvl;
    ovf_set = 1'b0;
    dry_set = 1'b0;
    if (bus.load_en) begin
      lvl_nxt = (bus.load_val > MAX_U) ? MAX_U : bus.load_val;
    end else if (tick) begin
      if (raw > MAX_S) begin
        lvl_nxt = MAX_U;
        ovf_set = 1'b1;
      end else if (raw < 0) begin
        lvl_nxt = '0;
        dry_set = 1'b1;
      end else begin
        lvl_nxt = raw[LEVEL_W-1:0];
      end
    end
    s_nxt = {lvl_nxt >= LEVEL_W'(T3), lvl_nxt >= LEVEL_W'(T2), lvl_nxt >= LEVEL_W'(T1)};
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      presc <= '0;
      lvl   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
      dry_q <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      lvl   <= lvl_nxt;
      s_q   <= s_nxt;
      ovf_q <= ovf_set | (ovf_q & ~bus.flag_clr);
      dry_q <= dry_set | (dry_q & ~bus.flag_clr);
    end
  end

  assign bus.level    = lvl;
  assign bus.s        = s_q;
  assign bus.tick     = tick;
  assign bus.ovf_flag = ovf_q;
  assign bus.dry_flag = dry_q;
endmodule
